// File: rtl/add_sub_hls_deadlock_reporter_if.sv
// Bundle of the monitor-block inputs, control inputs and report outputs of the
// HLS deadlock reporter. The master side drives the inputs; the slave is the reporter.
interface add_sub_hls_deadlock_reporter_if #(
  parameter int NUM_MON  = 4,
  parameter int THRESH_W = 16,
  parameter int IDX_W    = 2
);
  logic [NUM_MON-1:0]  block_in;
  logic                enable;
  logic [THRESH_W-1:0] threshold;
  logic                clear;
  logic                deadlock_detected;
  logic [IDX_W-1:0]    deadlock_idx;
  logic [NUM_MON-1:0]  block_snapshot;
  logic [THRESH_W-1:0] stall_cycles;
  logic                irq;

  modport master (
    output block_in, enable, threshold, clear,
    input  deadlock_detected, deadlock_idx, block_snapshot, stall_cycles, irq
  );

  modport slave (
    input  block_in, enable, threshold, clear,
    output deadlock_detected, deadlock_idx, block_snapshot, stall_cycles, irq
  );
endinterface

// File: rtl/add_sub_hls_deadlock_reporter.sv
// Qualifies a persistent HLS monitor 'block' as a deadlock and latches a sticky
// report (index, snapshot, stall length) with a one-cycle irq pulse.
module add_sub_hls_deadlock_reporter #(
  parameter int NUM_MON  = 4,
  parameter int THRESH_W = 16,
  parameter int IDX_W    = 2
) (
  input logic clock,
  input logic reset_n,
  add_sub_hls_deadlock_reporter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WATCH, REPORTED} state_t;

  state_t              state, state_nx;
  logic [THRESH_W-1:0] cnt, cnt_nx, eff_thr;
  logic [IDX_W-1:0]    cand, cand_nx, low_idx;
  logic                det, det_nx, irq_q, irq_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [NUM_MON-1:0]  snap, snap_nx;
  logic [THRESH_W-1:0] stall, stall_nx;

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = NUM_MON; i > 0; i--) begin
      if (bus.block_in[i-1]) low_idx = IDX_W'(i - 1);
    end
  end

  assign eff_thr = (bus.threshold == '0) ? THRESH_W'(1) : bus.threshold;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    det_nx   = det;
    idx_nx   = idx;
    snap_nx  = snap;
    stall_nx = stall;
    irq_nx   = 1'b0;
    if (bus.clear) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      cand_nx  = '0;
      det_nx   = 1'b0;
      idx_nx   = '0;
      snap_nx  = '0;
      stall_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable && (|bus.block_in)) begin
            state_nx = WATCH;
            cand_nx  = low_idx;
            cnt_nx   = THRESH_W'(1);
          end else begin
            cnt_nx = '0;
          end
        end
        WATCH: begin
          if (bus.enable && bus.block_in[cand]) begin
            if (cnt >= eff_thr) begin
              state_nx = REPORTED;
              det_nx   = 1'b1;
              idx_nx   = cand;
              snap_nx  = bus.block_in;
              stall_nx = cnt;
              irq_nx   = 1'b1;
            end else if (cnt != '1) begin
              cnt_nx = cnt + THRESH_W'(1);
            end
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        REPORTED: ;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
      det   <= 1'b0;
      idx   <= '0;
      snap  <= '0;
      stall <= '0;
      irq_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
      det   <= det_nx;
      idx   <= idx_nx;
      snap  <= snap_nx;
      stall <= stall_nx;
      irq_q <= irq_nx;
    end
  end

  assign bus.deadlock_detected = det;
  assign bus.deadlock_idx      = idx;
  assign bus.block_snapshot    = snap;
  assign bus.stall_cycles      = stall;
  assign bus.irq               = irq_q;

endmodule

// File: tb/tb_add_sub_hls_deadlock_reporter.sv
// Scoreboard bench for the deadlock reporter: a cycle-level reference model pushes
// expected reports, a negedge monitor pops and compares them against the DUT.
module tb_add_sub_hls_deadlock_reporter;
  localparam int NUM_MON  = 4;
  localparam int THRESH_W = 16;
  localparam int IDX_W    = 2;
  localparam int MAXCNT   = 65535;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  add_sub_hls_deadlock_reporter_if #(.NUM_MON(NUM_MON), .THRESH_W(THRESH_W), .IDX_W(IDX_W)) bus ();

  add_sub_hls_deadlock_reporter #(.NUM_MON(NUM_MON), .THRESH_W(THRESH_W), .IDX_W(IDX_W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int cyc;
    int idx;
    int snap;
    int stall;
  } rep_t;

  rep_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: "a monitor index is being timed" plus how many cycles it has been seen.
  bit m_timing, m_reported;
  int m_cand, m_seen;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [NUM_MON-1:0] v);
    for (int i = 0; i < NUM_MON; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_timing = 0; m_reported = 0; m_cand = 0; m_seen = 0;
      q.delete();
    end else begin
      int thr;
      cyc++;
      thr = (bus.threshold == 0) ? 1 : int'(bus.threshold);
      if (bus.clear) begin
        m_timing = 0; m_reported = 0; m_seen = 0;
      end else if (m_reported) begin
        // report frozen until cleared
      end else if (!m_timing) begin
        if (bus.enable && bus.block_in != 0) begin
          m_timing = 1; m_cand = lowest(bus.block_in); m_seen = 1;
        end
      end else if (bus.enable && bus.block_in[m_cand]) begin
        if (m_seen >= thr) begin
          rep_t r;
          r.cyc = cyc; r.idx = m_cand; r.snap = int'(bus.block_in); r.stall = m_seen;
          q.push_back(r);
          m_reported = 1; m_timing = 0;
        end else if (m_seen < MAXCNT) begin
          m_seen++;
        end
      end else begin
        m_timing = 0; m_seen = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("detected_flag", int'(bus.deadlock_detected), int'(m_reported));
      if (bus.irq) begin
        if (q.size() == 0) begin
          check("unexpected_irq", 1, 0);
        end else begin
          rep_t r;
          r = q.pop_front();
          check("irq_cycle", cyc, r.cyc);
          check("report_idx", int'(bus.deadlock_idx), r.idx);
          check("report_snapshot", int'(bus.block_snapshot), r.snap);
          check("report_stall", int'(bus.stall_cycles), r.stall);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        check("missing_irq", 0, 1);
        void'(q.pop_front());
      end
    end
  end

  task automatic do_clear();
    @(negedge clock);
    bus.clear = 1'b1; bus.block_in = '0;
    @(negedge clock);
    bus.clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.block_in = '0; bus.enable = 1'b0; bus.threshold = '0; bus.clear = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset_detected", int'(bus.deadlock_detected), 0);
    check("reset_irq", int'(bus.irq), 0);
    check("reset_stall", int'(bus.stall_cycles), 0);
    reset_n = 1'b1;

    // threshold 4, monitor 2 held: report at the 4th edge after capture
    @(negedge clock);
    bus.enable = 1'b1; bus.threshold = 16'd4; bus.block_in = 4'b0100;
    repeat (4) @(posedge clock); #1;
    check("t2_not_yet", int'(bus.deadlock_detected), 0);
    @(posedge clock); #1;
    check("t2_detected", int'(bus.deadlock_detected), 1);
    check("t2_irq", int'(bus.irq), 1);
    check("t2_idx", int'(bus.deadlock_idx), 2);
    check("t2_snap", int'(bus.block_snapshot), 4);
    check("t2_stall", int'(bus.stall_cycles), 4);
    @(posedge clock); #1;
    check("t2_irq_pulse", int'(bus.irq), 0);
    check("t2_sticky", int'(bus.deadlock_detected), 1);

    // async reset while reported, then mid-WATCH
    #2 reset_n = 1'b0; #1;
    check("t1_async_det", int'(bus.deadlock_detected), 0);
    check("t1_async_stall", int'(bus.stall_cycles), 0);
    @(negedge clock); reset_n = 1'b1;
    bus.threshold = 16'd100; bus.block_in = 4'b0001;
    repeat (6) @(posedge clock);
    #2 reset_n = 1'b0; #1;
    check("t1_watch_reset_det", int'(bus.deadlock_detected), 0);
    @(negedge clock); reset_n = 1'b1; bus.block_in = '0;
    repeat (2) @(negedge clock);

    // threshold 8, block for 5 cycles then drops: no detection
    bus.threshold = 16'd8; bus.block_in = 4'b0010;
    repeat (5) @(negedge clock);
    bus.block_in = '0;
    repeat (12) @(negedge clock);
    check("t3_no_detect", int'(bus.deadlock_detected), 0);

    // two candidates: bit1 drops, bit2 becomes the new candidate
    bus.threshold = 16'd3; bus.block_in = 4'b0110;
    repeat (3) @(negedge clock);
    bus.block_in = 4'b0100;
    repeat (10) @(negedge clock);
    check("t4_idx", int'(bus.deadlock_idx), 2);
    do_clear();

    // clear coincides with qualifying cycle, then re-detect with block held
    bus.block_in = 4'b1000;
    repeat (3) @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    check("t5_clear_wins", int'(bus.deadlock_detected), 0);
    repeat (6) @(negedge clock);
    check("t5_redetect", int'(bus.deadlock_detected), 1);
    check("t5_redetect_idx", int'(bus.deadlock_idx), 3);
    do_clear();

    // threshold 0 behaves like 1
    bus.threshold = 16'd0; bus.block_in = 4'b0001;
    repeat (2) @(posedge clock); #1;
    check("t6_thr0_det", int'(bus.deadlock_detected), 1);
    check("t6_thr0_stall", int'(bus.stall_cycles), 1);
    do_clear();

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 49) == 0) bus.threshold = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) bus.block_in[$urandom_range(0, NUM_MON-1)] ^= 1'b1;
      bus.enable = ($urandom_range(0, 31) != 0);
      bus.clear  = ($urandom_range(0, 40) == 0);
    end
    @(negedge clock);
    bus.clear = 1'b0; bus.enable = 1'b1;
    do_clear();

    // saturation: all-ones threshold reaches all-ones without wrapping
    bus.threshold = 16'hFFFF; bus.block_in = 4'b0001;
    repeat (65535) @(posedge clock); #1;
    check("t6_ffff_not_yet", int'(bus.deadlock_detected), 0);
    @(posedge clock); #1;
    check("t6_ffff_det", int'(bus.deadlock_detected), 1);
    check("t6_ffff_stall", int'(bus.stall_cycles), 65535);
    repeat (3) @(negedge clock);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
